// File: rtl/j1_pkg.sv
// Shared definitions for the J1 boot sequencer.
//   BOOT_MAGIC   : first byte of every program image frame
//   ADDR_W_DEF   : default word-address width of the J1 program RAM
//   boot_state_t : sequencer states
//   takes_bytes  : states in which the byte stream may be accepted
//   is_busy      : states reported on busy_o (frame in progress or releasing)
package j1_pkg;

   localparam logic [7:0]  BOOT_MAGIC = 8'hA5;
   localparam int unsigned ADDR_W_DEF = 13;

   typedef enum logic [3:0] {
      ST_MAGIC,
      ST_CNT_LO,
      ST_CNT_HI,
      ST_DAT_LO,
      ST_DAT_HI,
      ST_CSUM,
      ST_RELEASE,
      ST_RUN,
      ST_ERROR
   } boot_state_t;

   function automatic logic takes_bytes(input boot_state_t s);
      return (s == ST_MAGIC)  || (s == ST_CNT_LO) || (s == ST_CNT_HI) ||
             (s == ST_DAT_LO) || (s == ST_DAT_HI) || (s == ST_CSUM);
   endfunction

   function automatic logic is_busy(input boot_state_t s);
      return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DAT_LO) ||
             (s == ST_DAT_HI) || (s == ST_CSUM)   || (s == ST_RELEASE);
   endfunction

endpackage

// File: rtl/j1_boot_ctrl_if.sv
// Byte-stream input and J1 program-load bus of the boot sequencer.
//   in_data/in_valid/in_ready : image byte stream, transfer on valid & ready
//   pgm_addr/pgm_data/pgm_we  : J1 program-load port (byte address, word, strobe)
// Modports:
//   master : host side (drives bytes, observes the load port)
//   slave  : boot sequencer side
interface j1_boot_ctrl_if;

   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] pgm_addr;
   logic [15:0] pgm_data;
   logic        pgm_we;

   modport master (
      output in_data, in_valid,
      input  in_ready, pgm_addr, pgm_data, pgm_we
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, pgm_addr, pgm_data, pgm_we
   );

endinterface

// File: rtl/j1_boot_word_asm.sv
// Little-endian byte-pair to 16-bit word assembler for the J1 program port.
// The low byte is latched on lo_en_i; on hi_en_i the word {byte_i, low} and
// the byte address {index_i, 0} are registered and pgm_we_o is raised for
// exactly the following cycle. Address and data hold between writes.
// Ports:
//   sys_clk_i, sys_rst_n_i : clock, asynchronous active-low reset
//   abort_i                : suppresses any latch or write this cycle
//   lo_en_i, hi_en_i       : accepted low / high data byte strobes
//   byte_i                 : accepted byte
//   index_i                : word index of the word being completed
//   pgm_addr_o, pgm_data_o, pgm_we_o : J1 program-load port
module j1_boot_word_asm #(
   parameter int unsigned ADDR_W = 13
) (
   input  logic              sys_clk_i,
   input  logic              sys_rst_n_i,
   input  logic              abort_i,
   input  logic              lo_en_i,
   input  logic              hi_en_i,
   input  logic [7:0]        byte_i,
   input  logic [ADDR_W-1:0] index_i,
   output logic [15:0]       pgm_addr_o,
   output logic [15:0]       pgm_data_o,
   output logic              pgm_we_o
);

   logic [7:0]  lo_reg;
   logic [15:0] addr_reg;
   logic [15:0] data_reg;
   logic        we_reg;
   logic [7:0]  lane [2];
   logic [15:0] word;

   // Lane 0 is the stored low byte, lane 1 is the high byte arriving now.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         if (gi == 0) begin : g_lo
            assign lane[gi] = lo_reg;
         end else begin : g_hi
            assign lane[gi] = byte_i;
         end
      end
   endgenerate

   assign word = {lane[1], lane[0]};

   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         lo_reg   <= 8'h00;
         addr_reg <= 16'h0000;
         data_reg <= 16'h0000;
         we_reg   <= 1'b0;
      end else begin
         we_reg <= hi_en_i & ~abort_i;
         if (lo_en_i && !abort_i) begin
            lo_reg <= byte_i;
         end
         if (hi_en_i && !abort_i) begin
            data_reg <= word;
            addr_reg <= 16'({index_i, 1'b0});
         end
      end
   end

   assign pgm_addr_o = addr_reg;
   assign pgm_data_o = data_reg;
   assign pgm_we_o   = we_reg;

endmodule

// File: rtl/j1_boot_ctrl.sv
// Boot sequencer for the J1 core. Holds the CPU in reset, receives the
// framed image  A5, count_lo, count_hi, count x (lo, hi), csum  and writes
// each word to the J1 program port. A zero 8-bit sum over every byte after
// the magic byte (csum included) releases the CPU RELEASE_DLY+1 cycles after
// the csum byte is taken; a bad count or checksum parks in ERROR until
// load_req_i. load_req_i restarts the sequencer from any state.
// Ports:
//   sys_clk_i, sys_rst_n_i : clock, asynchronous active-low reset
//   bus        : byte stream in, program-load port out (slave modport)
//   load_req_i : 1-cycle pulse, abort and await a new image
//   cpu_rst_o  : J1 reset, high in every state except RUN
//   busy_o     : frame in progress or releasing
//   done_o     : 1-cycle pulse on RELEASE -> RUN
//   err_o      : sticky error, cleared by load_req_i or reset
module j1_boot_ctrl
   import j1_pkg::*;
#(
   parameter int unsigned ADDR_W        = ADDR_W_DEF,
   parameter int unsigned RELEASE_DLY   = 4,
   parameter bit          BOOT_ON_RESET = 1'b1
) (
   input  logic          sys_clk_i,
   input  logic          sys_rst_n_i,
   j1_boot_ctrl_if.slave bus,
   input  logic          load_req_i,
   output logic          cpu_rst_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o
);

   localparam int unsigned MAX_WORDS   = 1 << ADDR_W;
   localparam boot_state_t RESET_STATE = BOOT_ON_RESET ? ST_MAGIC : ST_RUN;

   boot_state_t       state_reg, state_next;
   logic [15:0]       count_reg, count_next;
   logic [7:0]        sum_reg, sum_next;
   logic [ADDR_W-1:0] index_reg, index_next;
   logic [7:0]        dly_reg, dly_next;
   logic              cpu_rst_reg;
   logic              done_reg;
   logic              err_reg;

   logic              in_ready;
   logic              accept;
   logic              lo_en;
   logic              hi_en;
   logic [7:0]        sum_plus;
   logic [15:0]       cnt_word;

   // load_req_i drops ready so a byte presented with it is never consumed.
   assign in_ready     = takes_bytes(state_reg) & ~load_req_i;
   assign bus.in_ready = in_ready;
   assign accept       = bus.in_valid & in_ready;
   assign sum_plus     = sum_reg + bus.in_data;
   assign cnt_word     = {bus.in_data, count_reg[7:0]};

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      sum_next   = sum_reg;
      index_next = index_reg;
      dly_next   = dly_reg;
      lo_en      = 1'b0;
      hi_en      = 1'b0;

      if (load_req_i) begin
         state_next = ST_MAGIC;
         sum_next   = 8'h00;
         index_next = '0;
      end else begin
         case (state_reg)
            ST_MAGIC: begin
               // Anything other than the magic byte is consumed and dropped.
               if (accept && bus.in_data == BOOT_MAGIC) begin
                  state_next = ST_CNT_LO;
                  sum_next   = 8'h00;
               end
            end
            ST_CNT_LO: begin
               if (accept) begin
                  count_next = {8'h00, bus.in_data};
                  sum_next   = sum_plus;
                  state_next = ST_CNT_HI;
               end
            end
            ST_CNT_HI: begin
               if (accept) begin
                  count_next = cnt_word;
                  sum_next   = sum_plus;
                  index_next = '0;
                  if (cnt_word == 16'h0000 || 32'(cnt_word) > MAX_WORDS) begin
                     state_next = ST_ERROR;
                  end else begin
                     state_next = ST_DAT_LO;
                  end
               end
            end
            ST_DAT_LO: begin
               if (accept) begin
                  lo_en      = 1'b1;
                  sum_next   = sum_plus;
                  state_next = ST_DAT_HI;
               end
            end
            ST_DAT_HI: begin
               if (accept) begin
                  hi_en      = 1'b1;
                  sum_next   = sum_plus;
                  index_next = index_reg + 1'b1;
                  // Compared wide: the index of the last word may wrap.
                  if (32'(index_reg) + 32'd1 == 32'(count_reg)) begin
                     state_next = ST_CSUM;
                  end else begin
                     state_next = ST_DAT_LO;
                  end
               end
            end
            ST_CSUM: begin
               if (accept) begin
                  sum_next = sum_plus;
                  if (sum_plus == 8'h00) begin
                     state_next = ST_RELEASE;
                     dly_next   = 8'(RELEASE_DLY);
                  end else begin
                     state_next = ST_ERROR;
                  end
               end
            end
            ST_RELEASE: begin
               if (dly_reg == 8'h00) begin
                  state_next = ST_RUN;
               end else begin
                  dly_next = dly_reg - 8'd1;
               end
            end
            ST_RUN, ST_ERROR: begin
               state_next = state_reg;
            end
            default: begin
               state_next = RESET_STATE;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         state_reg   <= RESET_STATE;
         count_reg   <= 16'h0000;
         sum_reg     <= 8'h00;
         index_reg   <= '0;
         dly_reg     <= 8'h00;
         cpu_rst_reg <= BOOT_ON_RESET;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         sum_reg     <= sum_next;
         index_reg   <= index_next;
         dly_reg     <= dly_next;
         // Registered from the next state so the CPU is held from the same
         // edge that leaves RUN and released on the edge that enters it.
         cpu_rst_reg <= (state_next != ST_RUN);
         done_reg    <= (state_reg == ST_RELEASE) && (state_next == ST_RUN);
         err_reg     <= load_req_i ? 1'b0 : (err_reg | (state_next == ST_ERROR));
      end
   end

   j1_boot_word_asm #(
      .ADDR_W (ADDR_W)
   ) u_word_asm (
      .sys_clk_i   (sys_clk_i),
      .sys_rst_n_i (sys_rst_n_i),
      .abort_i     (load_req_i),
      .lo_en_i     (lo_en),
      .hi_en_i     (hi_en),
      .byte_i      (bus.in_data),
      .index_i     (index_reg),
      .pgm_addr_o  (bus.pgm_addr),
      .pgm_data_o  (bus.pgm_data),
      .pgm_we_o    (bus.pgm_we)
   );

   assign cpu_rst_o = cpu_rst_reg;
   assign busy_o    = is_busy(state_reg);
   assign done_o    = done_reg;
   assign err_o     = err_reg;

endmodule

// File: tb/tb_j1_boot_ctrl.sv
// Directed bench for j1_boot_ctrl: good image, bad checksum, junk before
// magic, count limits, abort mid-frame, random-gap 64-word image, async
// reset mid-frame, and a BOOT_ON_RESET=0 instance.
module tb_j1_boot_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic load_req;
   logic cpu_rst, busy, done, err;
   logic load_req1;
   logic cpu_rst1, busy1, done1, err1;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;

   logic [15:0] wr_addr_q[$];
   logic [15:0] wr_data_q[$];
   logic [15:0] exp_addr_q[$];
   logic [15:0] exp_data_q[$];
   logic [7:0]  fq[$];

   always #5 clk = ~clk;

   j1_boot_ctrl_if bif ();
   j1_boot_ctrl_if bif1 ();

   j1_boot_ctrl #(.ADDR_W(13), .RELEASE_DLY(4), .BOOT_ON_RESET(1'b1)) dut0 (
      .sys_clk_i   (clk),
      .sys_rst_n_i (rst_n),
      .bus         (bif.slave),
      .load_req_i  (load_req),
      .cpu_rst_o   (cpu_rst),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   j1_boot_ctrl #(.ADDR_W(13), .RELEASE_DLY(4), .BOOT_ON_RESET(1'b0)) dut1 (
      .sys_clk_i   (clk),
      .sys_rst_n_i (rst_n),
      .bus         (bif1.slave),
      .load_req_i  (load_req1),
      .cpu_rst_o   (cpu_rst1),
      .busy_o      (busy1),
      .done_o      (done1),
      .err_o       (err1)
   );

   // Write and done monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (bif.pgm_we === 1'b1) begin
         wr_addr_q.push_back(bif.pgm_addr);
         wr_data_q.push_back(bif.pgm_data);
      end
      if (done === 1'b1) done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
   endtask

   task automatic check_writes(input string tag);
      int n;
      check($sformatf("%s_wr_count", tag), wr_addr_q.size(), exp_addr_q.size());
      n = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[i], exp_addr_q[i]);
         check($sformatf("%s_wr%0d_data", tag, i), wr_data_q[i], exp_data_q[i]);
      end
      wr_addr_q.delete();
      wr_data_q.delete();
      exp_addr_q.delete();
      exp_data_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bif.in_valid = 1'b0;
         #1;
      end
   endtask

   // Presents one byte and returns on the clock edge that accepts it.
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      int waited;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
         @(negedge clk);
         bif.in_valid = 1'b0;
      end
      @(negedge clk);
      bif.in_data  = b;
      bif.in_valid = 1'b1;
      #1;
      waited = 0;
      while (bif.in_ready !== 1'b1 && waited < 40) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (bif.in_ready !== 1'b1) check("ready_timeout", bif.in_ready, 1'b1);
      @(posedge clk);
   endtask

   task automatic send_frame(input int max_gap);
      foreach (fq[i]) send_byte(fq[i], max_gap);
   endtask

   // 1-cycle load request; optionally with a byte offered in the same cycle.
   task automatic pulse_load(input string tag, input logic hold_valid);
      @(negedge clk);
      bif.in_valid = hold_valid;
      bif.in_data  = 8'h99;
      load_req     = 1'b1;
      #1;
      check($sformatf("%s_abort_ready", tag), bif.in_ready, 1'b0);
      @(negedge clk);
      load_req     = 1'b0;
      bif.in_valid = 1'b0;
      #1;
      check($sformatf("%s_after_load_err", tag), err, 1'b0);
      check($sformatf("%s_after_load_cpu_rst", tag), cpu_rst, 1'b1);
      check($sformatf("%s_after_load_busy", tag), busy, 1'b0);
      check($sformatf("%s_after_load_ready", tag), bif.in_ready, 1'b1);
   endtask

   // Called right after the csum byte is accepted: cpu_rst_o must fall on
   // the fifth edge after it, together with a single done_o pulse.
   task automatic check_release(input string tag);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bif.in_valid = 1'b0;
         #1;
         check($sformatf("%s_hold%0d_cpu_rst", tag, i), cpu_rst, 1'b1);
         check($sformatf("%s_hold%0d_done", tag, i), done, 1'b0);
      end
      @(negedge clk);
      #1;
      check($sformatf("%s_rel_cpu_rst", tag), cpu_rst, 1'b0);
      check($sformatf("%s_rel_done", tag), done, 1'b1);
      @(negedge clk);
      #1;
      check($sformatf("%s_post_done", tag), done, 1'b0);
      check($sformatf("%s_run_ready", tag), bif.in_ready, 1'b0);
      check($sformatf("%s_run_busy", tag), busy, 1'b0);
      check($sformatf("%s_run_err", tag), err, 1'b0);
   endtask

   initial begin
      logic [7:0]  sum;
      logic [15:0] w;
      int          waited;

      rst_n         = 1'b0;
      load_req      = 1'b0;
      load_req1     = 1'b0;
      bif.in_data   = 8'h00;
      bif.in_valid  = 1'b0;
      bif1.in_data  = 8'h00;
      bif1.in_valid = 1'b0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      #1;
      check("rst_cpu_rst", cpu_rst, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_we", bif.pgm_we, 1'b0);
      check("rst_addr", bif.pgm_addr, 16'h0000);
      check("rst_data", bif.pgm_data, 16'h0000);
      check("rst_ready", bif.in_ready, 1'b1);
      check("nb_rst_cpu_rst", cpu_rst1, 1'b0);
      check("nb_rst_ready", bif1.in_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      check("nb_run_cpu_rst", cpu_rst1, 1'b0);
      check("nb_run_ready", bif1.in_ready, 1'b0);
      check("nb_run_busy", busy1, 1'b0);

      // ---- good image, back-to-back ----
      fq = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
      send_frame(0);
      check_release("good");
      exp_wr(16'h0000, 16'h1234);
      exp_wr(16'h0002, 16'hABCD);
      check_writes("good");
      check("good_addr_hold", bif.pgm_addr, 16'h0002);
      check("good_data_hold", bif.pgm_data, 16'hABCD);
      check("good_done_cnt", done_cnt, 1);

      // ---- bad checksum -> ERROR, then recover ----
      pulse_load("run_load", 1'b0);
      fq = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h41};
      send_frame(0);
      idle(2);
      check("badcs_err", err, 1'b1);
      check("badcs_cpu_rst", cpu_rst, 1'b1);
      check("badcs_ready", bif.in_ready, 1'b0);
      check("badcs_busy", busy, 1'b0);
      exp_wr(16'h0000, 16'h1234);
      exp_wr(16'h0002, 16'hABCD);
      check_writes("badcs");
      pulse_load("badcs_load", 1'b0);

      // ---- junk before magic, then a good frame ----
      fq = '{8'h00, 8'hFF, 8'h5A};
      send_frame(0);
      idle(1);
      check("junk_busy", busy, 1'b0);
      check("junk_err", err, 1'b0);
      fq = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
      send_frame(0);
      check_release("junk");
      exp_wr(16'h0000, 16'h1234);
      exp_wr(16'h0002, 16'hABCD);
      check_writes("junk");
      check("junk_done_cnt", done_cnt, 2);
      pulse_load("junk_load", 1'b0);

      // ---- count limits ----
      fq = '{8'hA5, 8'h00, 8'h00};
      send_frame(0);
      idle(1);
      check("cnt0_err", err, 1'b1);
      check("cnt0_ready", bif.in_ready, 1'b0);
      pulse_load("cnt0_load", 1'b0);
      fq = '{8'hA5, 8'h01, 8'h20};
      send_frame(0);
      idle(1);
      check("cnt2001_err", err, 1'b1);
      pulse_load("cnt2001_load", 1'b0);
      fq = '{8'hA5, 8'h00, 8'h20};
      send_frame(0);
      idle(1);
      check("cnt2000_err", err, 1'b0);
      check("cnt2000_busy", busy, 1'b1);
      check("cnt2000_ready", bif.in_ready, 1'b1);
      pulse_load("cnt2000_load", 1'b0);
      check_writes("cnt");

      // ---- abort after one word, then a fresh 1-word frame ----
      fq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
      send_frame(0);
      pulse_load("abort", 1'b1);
      fq = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'h52};
      send_frame(0);
      check_release("fresh");
      exp_wr(16'h0000, 16'h2211);
      exp_wr(16'h0000, 16'hBEEF);
      check_writes("abort");
      check("fresh_done_cnt", done_cnt, 3);

      // ---- 64 random words with random valid gaps ----
      pulse_load("rand_load", 1'b0);
      fq  = '{8'hA5, 8'h40, 8'h00};
      sum = 8'h40;
      for (int i = 0; i < 64; i++) begin
         w = 16'($urandom);
         fq.push_back(w[7:0]);
         fq.push_back(w[15:8]);
         sum = sum + w[7:0] + w[15:8];
         exp_wr(16'(i * 2), w);
      end
      fq.push_back(8'h00 - sum);
      send_frame(2);
      waited = 0;
      while (cpu_rst === 1'b1 && waited < 30) begin
         @(negedge clk);
         bif.in_valid = 1'b0;
         #1;
         waited++;
      end
      check("rand_release", cpu_rst, 1'b0);
      idle(2);
      check_writes("rand");
      check("rand_done_cnt", done_cnt, 4);
      check("rand_err", err, 1'b0);

      // ---- async reset mid-frame ----
      pulse_load("mid_load", 1'b0);
      fq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};
      send_frame(0);
      idle(2);
      check("mid_pre_busy", busy, 1'b1);
      check("mid_pre_data", bif.pgm_data, 16'h5678);
      exp_wr(16'h0000, 16'h5678);
      check_writes("mid");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_cpu_rst", cpu_rst, 1'b1);
      check("arst_busy", busy, 1'b0);
      check("arst_we", bif.pgm_we, 1'b0);
      check("arst_addr", bif.pgm_addr, 16'h0000);
      check("arst_data", bif.pgm_data, 16'h0000);
      check("arst_err", err, 1'b0);
      check("arst_ready", bif.in_ready, 1'b1);
      check("nb_arst_cpu_rst", cpu_rst1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check("nb_after_cpu_rst", cpu_rst1, 1'b0);
      check("nb_after_ready", bif1.in_ready, 1'b0);
      check("nb_after_we", bif1.pgm_we, 1'b0);
      check("after_cpu_rst", cpu_rst, 1'b1);
      check("after_busy", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/j1_boot_ctrl.md
Name: j1_boot_ctrl

Overview:
Boot sequencer for the J1 core. Holds the CPU in reset and receives a framed program image as a byte stream (valid/ready). Assembles little-endian 16-bit words and drives the J1 program-load port (byte address, data, write enable). On a good checksum, releases the CPU after a settle delay. Sits between the host/UART byte source and the j1 sys_rst_i/pgm_* inputs.

Parameters:
ADDR_W, 13, word-address width of program RAM; MAX_WORDS = 2**ADDR_W
RELEASE_DLY, 4, cycles cpu_rst_o stays high after checksum accepted (range 1..255)
BOOT_ON_RESET, 1, 1: wait for image after reset; 0: go straight to RUN (image preloaded)

Ports:
sys_clk_i  in  1  clock
sys_rst_n_i  in  1  reset, asynchronous, active-low
in_data_i  in  8  image byte
in_valid_i  in  1  byte valid
in_ready_o  out  1  byte accepted when in_valid_i & in_ready_o
load_req_i  in  1  1-cycle pulse: abort anything, hold CPU, await new image
cpu_rst_o  out  1  to j1 sys_rst_i; 1 = CPU held
pgm_addr_o  out  16  byte address (2*word index) to j1 pgm_addr
pgm_data_o  out  16  word to j1 pgm_data
pgm_we_o  out  1  to j1 pgm_we
busy_o  out  1  state in CNT_LO..RELEASE
done_o  out  1  1-cycle pulse on entry to RUN from RELEASE
err_o  out  1  sticky error, cleared only by load_req_i or reset

Behaviour:
- Frame: 0xA5, count_lo, count_hi, count×(lo, hi), csum. count = words, 1..MAX_WORDS.
- csum: 8-bit sum (mod 256) of all bytes after the magic byte, including csum, must be 0x00.
- States: MAGIC, CNT_LO, CNT_HI, DAT_LO, DAT_HI, CSUM, RELEASE, RUN, ERROR.
- Reset (async assert): state = MAGIC if BOOT_ON_RESET, else RUN. cpu_rst_o = BOOT_ON_RESET. pgm_we_o=0, pgm_addr_o=0, pgm_data_o=0, done_o=0, err_o=0. Word index=0, sum=0, delay counter=0.
- in_ready_o = 1 in MAGIC..CSUM and ~load_req_i. It is 0 in RELEASE, RUN, ERROR.
- MAGIC: accepted 0xA5 -> CNT_LO (sum cleared). Any other byte is dropped and state stays MAGIC.
- CNT_LO/CNT_HI: latch count and add bytes to sum. After CNT_HI: count==0 or count>MAX_WORDS -> ERROR, else DAT_LO with index=0.
- DAT_LO: latch low byte -> DAT_HI.
- DAT_HI: form word {hi,lo}. In the next cycle pgm_we_o=1 for exactly 1 cycle, with pgm_data_o=word and pgm_addr_o=index<<1. Then index+1. If index+1==count -> CSUM, else DAT_LO.
- pgm_addr_o/pgm_data_o hold their value between writes.
- Back-to-back bytes every cycle are sustained with no stall.
- CSUM: (sum+byte)==0 -> RELEASE with counter=RELEASE_DLY, else ERROR.
- RELEASE: counter decrements each cycle. When it reaches 0: cpu_rst_o<=0, done_o pulses, state -> RUN. cpu_rst_o therefore falls RELEASE_DLY+1 cycles after the csum byte is accepted.
- cpu_rst_o = 1 in every state except RUN.
- ERROR: err_o<=1, cpu_rst_o stays 1, no writes. Only load_req_i exits.
- load_req_i (any state, including mid-frame, RELEASE and RUN): next state MAGIC, cpu_rst_o<=1, err_o<=0, sum/index cleared. Any pending pgm_we_o is suppressed. load_req_i wins over a simultaneous byte, since in_ready_o=0 in that cycle.
- Partial image after abort: words already written remain in RAM. This is acceptable.
- Width: sum wraps mod 256. Address = {index,1'b0} zero-extended to 16 bits, max 2*(MAX_WORDS-1).

Decomposition:
- Shared package j1_pkg holds: BOOT_MAGIC=8'hA5, state enum (9 states), ADDR_W default.
- One natural sub-module: j1_boot_word_asm (byte-pair to word assembler with 1-cycle write strobe). The FSM, sum and release counter stay in the top module.

Test Plan:
- Good image, back-to-back bytes A5 02 00 34 12 CD AB 40 -> pgm_we_o twice: (addr 0x0000, 0x1234) then (0x0002, 0xABCD). cpu_rst_o falls 5 cycles after 0x40 accepted (RELEASE_DLY=4). done_o pulses once. err_o=0.
- Same frame with csum 0x41 -> ERROR, err_o=1, cpu_rst_o stays 1, in_ready_o=0. Then load_req_i pulse -> err_o=0, state MAGIC.
- Junk 00 FF 5A, then a valid frame -> junk dropped, image loads normally. count=0 (A5 00 00) -> ERROR. count=0x2001 with ADDR_W=13 -> ERROR.
- load_req_i asserted after 1 data word, then a fresh 1-word frame A5 01 00 EF BE 52 -> writes (0x0000, 0xBEEF) and releases. Abort cycle shows in_ready_o=0.
- sys_rst_n_i asserted mid-frame -> outputs return to reset values immediately (async). BOOT_ON_RESET=0 build -> cpu_rst_o=0 right after reset, in_ready_o=0.
- Random in_valid_i gaps with 64-word random image -> all 64 writes correct with addresses 0..0x7E, exactly 64 pgm_we_o pulses.
